wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the pipelined core; sits directly downstream of the LSU.
- Accepts one retiring instruction per valid/ready handshake, with its final result, CSR write data and next PC.
- Commits the GPR write, owns the machine CSR file (mstatus, mtvec, mepc, mcause) and resolves ecall/mret/ebreak.
- Publishes the committed PC to the IFU, the retired instruction for hazard checks, and a 64-bit retire counter.

Parameters:
- RESET_MSTATUS, 32'h0000_1800, mstatus reset value (MPP=M).
- RESET_PC, 32'h3000_0000, value of commit_pc after reset.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  LSU has a retiring instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  32  instruction PC
- in_next_pc  in  32  sequential/branch-resolved next PC
- in_result  in  32  rd value (load data, ALU result, old CSR value, link address)
- in_csr_wdata  in  32  new CSR value for CSR instructions
- csr_raddr  in  12  EXU CSR read address
- csr_rdata  out  32  combinational CSR read data
- rf_wen  out  1  GPR write enable
- rf_waddr  out  5  GPR write address
- rf_wdata  out  32  GPR write data
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  32  PC the IFU must fetch next
- wb_inst  out  32  instruction held in stage (hazard compare)
- wb_result  out  32  result held in stage (forwarding)
- retire_count  out  64  retired-instruction count
- halt  out  1  sticky, set on ebreak

Behaviour:
- Reset values:
  - Outputs: in_ready=1, rf_wen=0, rf_waddr=0, rf_wdata=0, commit_valid=0, commit_pc=RESET_PC, wb_inst=32'h0000_0013 (nop), wb_result=0, retire_count=0, halt=0.
  - CSRs: mstatus=RESET_MSTATUS, mtvec=mepc=mcause=0.
  - State: IDLE.
- States IDLE and COMMIT.
  - IDLE: in_ready=1. On in_valid, latch inst/pc/next_pc/result/csr_wdata and go to COMMIT.
  - COMMIT: in_ready=0. Always returns to IDLE next cycle.
  - Throughput: one instruction per 2 cycles.
- Latency: handshake at edge N puts the instruction in COMMIT during cycle N..N+1. In that cycle rf_wen and commit_valid pulse for exactly one cycle. The GPR and CSR writes take effect at edge N+1.
- wb_inst and wb_result hold the last latched values until the next accept.
- rf_wen: asserted in COMMIT when opcode is one of LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011, or SYSTEM 1110011 with func3!=0 — and rd (inst[11:7]) != 0.
  - rf_waddr=rd, rf_wdata=latched result.
  - rf_waddr/rf_wdata are 0 whenever rf_wen=0.
- CSR write: SYSTEM with func3 in {001,101} always writes CSR inst[31:20] with csr_wdata.
  - func3 in {010,011,110,111} writes only if inst[19:15]!=0.
  - Unimplemented addresses: write ignored, read returns 0.
- csr_rdata is combinational from current CSR state. A same-cycle read of a CSR being written returns the old value.
- commit_pc, updated at the COMMIT edge:
  - ecall (32'h0000_0073): mepc<=pc, mcause<=11, commit_pc<=mtvec.
  - mret (32'h3020_0073): commit_pc<=mepc.
  - Otherwise: commit_pc<=next_pc.
- ebreak (32'h0010_0073): halt<=1 (sticky until reset). commit_pc<=next_pc; no other effect.
- retire_count increments by 1 in every COMMIT cycle and wraps at 2^64-1 -> 0.
- Reset asserted in COMMIT: all writes at that edge are suppressed, reset values load, and no retire is counted.
- in_valid while in COMMIT is ignored; the upstream holds it.

Test Plan:
- addi x5 (0x00A00293), result=10, pc=0x3000_0000, next_pc=0x3000_0004 -> COMMIT cycle has rf_wen=1, waddr=5, wdata=10, commit_valid=1; commit_pc=0x3000_0004 after the edge; retire_count=1; in_ready low for one cycle.
- sw (opcode 0100011) and addi x0 -> rf_wen=0 and rf_waddr=0 both times; commit_valid pulses twice; retire_count=2.
- csrrw x1, mtvec, rs1 with csr_wdata=0x8000_0100, result=0 -> x1<=0; the next csr_raddr=0x305 reads 0x8000_0100. csrrs with rs1=x0 on mtvec -> mtvec unchanged.
- mtvec=0x8000_0100, ecall at pc 0x3000_0040 -> mepc=0x3000_0040, mcause=11, commit_pc=0x8000_0100. Then mret -> commit_pc=0x3000_0040.
- ebreak -> halt=1 and stays 1 across further commits until reset.
- Reset asserted in COMMIT of addi x5 -> no rf_wen, retire_count=0, commit_pc=0x3000_0000, in_ready=1 the next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: commits the GPR write, owns the machine CSRs, redirects the PC on ecall/mret.
// Two-cycle occupancy: accept in IDLE, commit one cycle later; in_ready is low while committing.
module wb_stage #(
  parameter logic [31:0] RESET_MSTATUS = 32'h0000_1800,
  parameter logic [31:0] RESET_PC      = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_next_pc,
  input  logic [31:0] in_result,
  input  logic [31:0] in_csr_wdata,
  input  logic [11:0] csr_raddr,
  output logic [31:0] csr_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        commit_valid,
  output logic [31:0] commit_pc,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_result,
  output logic [63:0] retire_count,
  output logic        halt
);

  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t      state, state_next;
  logic        commit;
  logic [31:0] pc_q, next_pc_q, csr_wdata_q;
  logic [31:0] mstatus, mtvec, mepc, mcause;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic [2:0]  func3;
  logic [11:0] csr_addr;
  logic        writes_rd, csr_wr_kind, csr_we;
  logic        is_ecall, is_mret, is_ebreak;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A reset landing in COMMIT must not let the retire escape to the register file.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = COMMIT;
      end
      COMMIT: begin
        commit     = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign commit_valid = commit;

  assign opcode   = wb_inst[6:0];
  assign rd       = wb_inst[11:7];
  assign func3    = wb_inst[14:12];
  assign rs1      = wb_inst[19:15];
  assign csr_addr = wb_inst[31:20];

  assign is_ecall  = (wb_inst == INST_ECALL);
  assign is_mret   = (wb_inst == INST_MRET);
  assign is_ebreak = (wb_inst == INST_EBREAK);

  always_comb begin
    writes_rd = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP: writes_rd = 1'b1;
      OP_SYSTEM: writes_rd = (func3 != 3'b000);
      default:   writes_rd = 1'b0;
    endcase
  end

  // Set/clear forms with rs1/zimm of zero are pure reads.
  always_comb begin
    csr_wr_kind = 1'b0;
    case (func3)
      3'b001, 3'b101:                 csr_wr_kind = 1'b1;
      3'b010, 3'b011, 3'b110, 3'b111: csr_wr_kind = (rs1 != 5'd0);
      default:                        csr_wr_kind = 1'b0;
    endcase
  end

  assign csr_we = commit && (opcode == OP_SYSTEM) && csr_wr_kind;

  assign rf_wen   = commit && writes_rd && (rd != 5'd0);
  assign rf_waddr = rf_wen ? rd : 5'd0;
  assign rf_wdata = rf_wen ? wb_result : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_inst     <= INST_NOP;
      wb_result   <= 32'd0;
      pc_q        <= 32'd0;
      next_pc_q   <= 32'd0;
      csr_wdata_q <= 32'd0;
    end else if (state == IDLE && in_valid) begin
      wb_inst     <= in_inst;
      wb_result   <= in_result;
      pc_q        <= in_pc;
      next_pc_q   <= in_next_pc;
      csr_wdata_q <= in_csr_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      commit_pc    <= RESET_PC;
      retire_count <= 64'd0;
      halt         <= 1'b0;
      mstatus      <= RESET_MSTATUS;
      mtvec        <= 32'd0;
      mepc         <= 32'd0;
      mcause       <= 32'd0;
    end else if (commit) begin
      retire_count <= retire_count + 64'd1;
      if (is_ecall)     commit_pc <= mtvec;
      else if (is_mret) commit_pc <= mepc;
      else              commit_pc <= next_pc_q;
      if (is_ebreak) halt <= 1'b1;
      if (is_ecall) begin
        mepc   <= pc_q;
        mcause <= 32'd11;
      end
      if (csr_we) begin
        case (csr_addr)
          CSR_MSTATUS: mstatus <= csr_wdata_q;
          CSR_MTVEC:   mtvec   <= csr_wdata_q;
          CSR_MEPC:    mepc    <= csr_wdata_q;
          CSR_MCAUSE:  mcause  <= csr_wdata_q;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_raddr)
      CSR_MSTATUS: csr_rdata = mstatus;
      CSR_MTVEC:   csr_rdata = mtvec;
      CSR_MEPC:    csr_rdata = mepc;
      CSR_MCAUSE:  csr_rdata = mcause;
      default:     csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: retire-level model checked every cycle plus literal spot checks.
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst, in_pc, in_next_pc, in_result, in_csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_valid;
  logic [31:0] commit_pc, wb_inst, wb_result;
  logic [63:0] retire_count;
  logic        halt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: what the stage holds and what has architecturally retired.
  bit          m_busy;
  logic [31:0] m_inst, m_pc, m_npc, m_res, m_cwd;
  logic [31:0] m_cpc, m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_cnt;
  bit          m_halt;

  wb_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_next_pc(in_next_pc),
    .in_result(in_result), .in_csr_wdata(in_csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .wb_inst(wb_inst), .wb_result(wb_result),
    .retire_count(retire_count), .halt(halt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit gpr_writer(input logic [31:0] inst);
    logic [6:0] op;
    op = inst[6:0];
    if (op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                   7'b0000011, 7'b0010011, 7'b0110011}) return 1'b1;
    if (op == 7'b1110011 && inst[14:12] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit csr_writer(input logic [31:0] inst);
    logic [2:0] f3;
    f3 = inst[14:12];
    if (inst[6:0] != 7'b1110011) return 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) return 1'b1;
    if (f3 inside {3'b010, 3'b011, 3'b110, 3'b111}) return inst[19:15] != 5'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] csr_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  task automatic retire();
    logic [31:0] target;
    target = m_npc;
    if (m_inst == 32'h0000_0073) begin
      target   = m_mtvec;
      m_mepc   = m_pc;
      m_mcause = 32'd11;
    end else if (m_inst == 32'h3020_0073) begin
      target = m_mepc;
    end else if (m_inst == 32'h0010_0073) begin
      m_halt = 1'b1;
    end
    if (csr_writer(m_inst)) begin
      case (m_inst[31:20])
        12'h300: m_mstatus = m_cwd;
        12'h305: m_mtvec   = m_cwd;
        12'h341: m_mepc    = m_cwd;
        12'h342: m_mcause  = m_cwd;
        default: ;
      endcase
    end
    m_cpc = target;
    m_cnt = m_cnt + 64'd1;
  endtask

  task automatic model_edge();
    if (reset) begin
      m_busy = 1'b0; m_inst = 32'h13; m_res = 32'd0; m_pc = 32'd0; m_npc = 32'd0; m_cwd = 32'd0;
      m_cpc = 32'h3000_0000; m_cnt = 64'd0; m_halt = 1'b0;
      m_mstatus = 32'h0000_1800; m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    end else if (m_busy) begin
      retire();
      m_busy = 1'b0;
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_inst = in_inst; m_pc = in_pc; m_npc = in_next_pc; m_res = in_result; m_cwd = in_csr_wdata;
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      bit ew;
      ew = m_busy && !reset && gpr_writer(m_inst) && (m_inst[11:7] != 5'd0);
      chk("in_ready", in_ready, !m_busy);
      chk("commit_valid", commit_valid, m_busy && !reset);
      chk("rf_wen", rf_wen, ew);
      chk("rf_waddr", rf_waddr, ew ? m_inst[11:7] : 5'd0);
      chk("rf_wdata", rf_wdata, ew ? m_res : 32'd0);
      chk("commit_pc", commit_pc, m_cpc);
      chk("wb_inst", wb_inst, m_inst);
      chk("wb_result", wb_result, m_res);
      chk("retire_count", retire_count, m_cnt);
      chk("halt", halt, m_halt);
      chk("csr_rdata", csr_rdata, csr_read(csr_raddr));
    end
  end

  task automatic clk();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic accept(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [31:0] res, input logic [31:0] cwd);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; in_next_pc = npc;
    in_result = res; in_csr_wdata = cwd;
    clk();
    in_valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] npc,
                       input logic [31:0] res, input logic [31:0] cwd);
    accept(inst, pc, npc, res, cwd);
    clk();
  endtask

  task automatic rd_csr(input logic [11:0] a, input logic [31:0] exp);
    csr_raddr = a;
    #1;
    chk($sformatf("csr_%h", a), csr_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; in_next_pc = 32'd0;
    in_result = 32'd0; in_csr_wdata = 32'd0; csr_raddr = 12'h300;
    clk(); clk();
    reset = 1'b0;
    chk_en = 1'b1;

    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_commit_pc", commit_pc, 32'h3000_0000);
    chk("rst_wb_inst", wb_inst, 32'h0000_0013);
    chk("rst_retire", retire_count, 64'd0);
    chk("rst_halt", halt, 1'b0);
    rd_csr(12'h300, 32'h0000_1800);
    rd_csr(12'h305, 32'h0);

    // addi x5, x0, 10
    accept(32'h00A0_0293, 32'h3000_0000, 32'h3000_0004, 32'd10, 32'd0);
    chk("addi_rf_wen", rf_wen, 1'b1);
    chk("addi_waddr", rf_waddr, 5'd5);
    chk("addi_wdata", rf_wdata, 32'd10);
    chk("addi_cvalid", commit_valid, 1'b1);
    chk("addi_in_ready", in_ready, 1'b0);
    clk();
    chk("addi_cpc", commit_pc, 32'h3000_0004);
    chk("addi_retire", retire_count, 64'd1);
    chk("addi_ready_back", in_ready, 1'b1);

    // sw, with the next instruction (addi x0) presented during its commit cycle
    accept(32'h0051_2023, 32'h3000_0004, 32'h3000_0008, 32'h1234, 32'd0);
    chk("sw_rf_wen", rf_wen, 1'b0);
    chk("sw_waddr", rf_waddr, 5'd0);
    in_valid = 1'b1; in_inst = 32'h0010_0013; in_pc = 32'h3000_0008;
    in_next_pc = 32'h3000_000C; in_result = 32'd1; in_csr_wdata = 32'd0;
    clk();
    chk("hold_wb_inst", wb_inst, 32'h0051_2023);
    clk();
    in_valid = 1'b0;
    chk("x0_rf_wen", rf_wen, 1'b0);
    chk("x0_waddr", rf_waddr, 5'd0);
    chk("x0_cvalid", commit_valid, 1'b1);
    clk();
    chk("store_retire", retire_count, 64'd3);

    // csrrw x1, mtvec, x2
    accept(32'h3051_10F3, 32'h3000_000C, 32'h3000_0010, 32'd0, 32'h8000_0100);
    chk("csrrw_waddr", rf_waddr, 5'd1);
    chk("csrrw_wdata", rf_wdata, 32'd0);
    rd_csr(12'h305, 32'h0);
    clk();
    rd_csr(12'h305, 32'h8000_0100);
    // csrrs x3, mtvec, x0: read only
    issue(32'h3050_21F3, 32'h3000_0010, 32'h3000_0014, 32'h8000_0100, 32'hDEAD_BEEF);
    rd_csr(12'h305, 32'h8000_0100);
    // csrrwi x0, mcause, 0: writes despite zero immediate
    issue(32'h3420_5073, 32'h3000_0014, 32'h3000_0018, 32'd0, 32'd5);
    rd_csr(12'h342, 32'd5);
    // csrrw to unimplemented mscratch
    issue(32'h3401_1073, 32'h3000_0018, 32'h3000_001C, 32'd0, 32'h55);
    rd_csr(12'h340, 32'd0);

    issue(32'h0000_0073, 32'h3000_0040, 32'h3000_0044, 32'd0, 32'd0);
    chk("ecall_cpc", commit_pc, 32'h8000_0100);
    rd_csr(12'h341, 32'h3000_0040);
    rd_csr(12'h342, 32'd11);
    issue(32'h3020_0073, 32'h8000_0100, 32'h8000_0104, 32'd0, 32'd0);
    chk("mret_cpc", commit_pc, 32'h3000_0040);

    issue(32'h0010_0073, 32'h3000_0040, 32'h3000_0044, 32'd0, 32'd0);
    chk("ebreak_halt", halt, 1'b1);
    chk("ebreak_cpc", commit_pc, 32'h3000_0044);
    issue(32'h00A0_0293, 32'h3000_0044, 32'h3000_0048, 32'd10, 32'd0);
    chk("halt_sticky", halt, 1'b1);
    chk("total_retire", retire_count, 64'd11);

    // reset arriving while an addi sits in COMMIT
    accept(32'h00A0_0293, 32'h3000_0048, 32'h3000_004C, 32'd10, 32'd0);
    reset = 1'b1;
    #1;
    chk("rstc_rf_wen", rf_wen, 1'b0);
    chk("rstc_cvalid", commit_valid, 1'b0);
    clk();
    reset = 1'b0;
    chk("rstc_retire", retire_count, 64'd0);
    chk("rstc_cpc", commit_pc, 32'h3000_0000);
    chk("rstc_in_ready", in_ready, 1'b1);
    chk("rstc_halt", halt, 1'b0);
    rd_csr(12'h305, 32'h0);
    rd_csr(12'h300, 32'h0000_1800);
    clk(); clk();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
